// File: rtl/led_flow.sv
// LED chase pattern generator stepped by falling edges of an idle-high tick strobe.
// Optional ping-pong mode is built only when LED_FLOW_PINGPONG_EN is defined.
module led_flow #(
  parameter int LED_W    = 4,
  parameter int STEP_DIV = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             tick_in,
  input  logic [1:0]       mode,
  input  logic             pause,
  output logic [LED_W-1:0] led_out,
  output logic             step_pulse
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  localparam logic [7:0]       DIV_LAST = 8'(STEP_DIV - 1);
  localparam logic [LED_W-1:0] LSB_ONE  = LED_W'(1);
  localparam logic [1:0]       M_ROTL   = 2'b00;
  localparam logic [1:0]       M_ROTR   = 2'b01;
  localparam logic [1:0]       M_PING   = 2'b10;

  state_t           state;
  logic             tick_d;
  logic [7:0]       div_cnt;
  logic             tick_fall;
  logic             qual;
  logic             step;
  logic [LED_W-1:0] nxt_led;

  // A held-low strobe yields one edge: only the high->low transition counts.
  assign tick_fall = tick_d & ~tick_in;
  assign qual      = tick_fall & ~pause & ((state == IDLE) || (state == RUN));
  assign step      = qual & (div_cnt == DIV_LAST);

`ifdef LED_FLOW_PINGPONG_EN
  logic dir;        // 0 = left, 1 = right
  logic nxt_dir;
  logic go_left;

  // Bounce off the end rather than shift out, so the pattern stays one-hot
  // even if ping-pong is entered with the lit LED already at an end.
  assign go_left = dir ? led_out[0] : ~led_out[LED_W-1];
`endif

  always_comb begin
    nxt_led = led_out;
`ifdef LED_FLOW_PINGPONG_EN
    nxt_dir = dir;
`endif
    if (led_out == '0) begin
      nxt_led = LSB_ONE;
    end else begin
      case (mode)
        M_ROTL: nxt_led = {led_out[LED_W-2:0], led_out[LED_W-1]};
        M_ROTR: nxt_led = {led_out[0], led_out[LED_W-1:1]};
`ifdef LED_FLOW_PINGPONG_EN
        M_PING: begin
          nxt_led = go_left ? (led_out << 1) : (led_out >> 1);
          if (nxt_led[LED_W-1])  nxt_dir = 1'b1;
          else if (nxt_led[0])   nxt_dir = 1'b0;
          else                   nxt_dir = ~go_left;
        end
`endif
        default: nxt_led = led_out;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      tick_d     <= 1'b0;
      div_cnt    <= '0;
      led_out    <= '0;
      step_pulse <= 1'b0;
    end else begin
      tick_d     <= tick_in;
      step_pulse <= 1'b0;
      if (qual)
        div_cnt <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
      case (state)
        IDLE: begin
          led_out <= '0;
          if (step) begin
            led_out    <= LSB_ONE;
            step_pulse <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state <= PAUSED;
          end else if (step) begin
            led_out    <= nxt_led;
            step_pulse <= 1'b1;
          end
        end
        PAUSED: begin
          if (!pause) state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LED_FLOW_PINGPONG_EN
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      dir <= 1'b0;
    else if (mode != M_PING)
      dir <= 1'b0;
    else if ((state == RUN) && step)
      dir <= nxt_dir;
  end
`endif

endmodule
